// File: rtl/pipeline_stall_flush_controller_if.sv
// Hazard inputs, per-stage hold/bubble controls and performance counters shared
// between the pipeline and its stall/flush controller.
interface pipeline_stall_flush_controller_if #(
    parameter int CNT_W = 32
);
    logic             load_use_hazard;
    logic             branch_taken_EX;
    logic             imem_busy;
    logic             dmem_busy;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_stall;
    logic             halted;
    logic [CNT_W-1:0] cnt_load_stall;
    logic [CNT_W-1:0] cnt_mem_wait;
    logic [CNT_W-1:0] cnt_flush;

    modport master (
        output load_use_hazard, branch_taken_EX, imem_busy, dmem_busy,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_stall, mem_wb_stall, halted,
        input  cnt_load_stall, cnt_mem_wait, cnt_flush
    );

    modport slave (
        input  load_use_hazard, branch_taken_EX, imem_busy, dmem_busy,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_stall, mem_wb_stall, halted,
        output cnt_load_stall, cnt_mem_wait, cnt_flush
    );
endinterface

// File: rtl/pipeline_stall_flush_controller.sv
// Stall/flush sequencer for the 5-stage pipe with a dmem-busy timeout watchdog.
// Define PIPE_CTRL_PERF_CNT_EN to build the saturating performance counters.
//
//   state      | meaning
//   RUN        | normal flow, hazards evaluated by priority
//   LOAD_STALL | one load-use bubble issued, hazard flag ignored this cycle
//   MEM_WAIT   | pipe frozen on dmem_busy, wait counter running
//   HALT       | watchdog expired, pipe frozen until reset
module pipeline_stall_flush_controller #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input logic                             CLK,
    input logic                             RESET,
    pipeline_stall_flush_controller_if.slave ctrl
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, HALT} state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              halt_now;
    logic              freeze;
    logic              do_flush;
    logic              do_bubble;
    logic              do_imem;
    logic              if_id_flush_raw;
    logic              id_ex_flush_raw;

    assign halt_now = (state == HALT);

    always_comb begin
        freeze     = 1'b0;
        do_flush   = 1'b0;
        do_bubble  = 1'b0;
        do_imem    = 1'b0;
        state_next = RUN;
        if (halt_now) begin
            state_next = HALT;
        end else if (ctrl.dmem_busy) begin
            freeze     = 1'b1;
            state_next = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) ? HALT : MEM_WAIT;
        end else if (ctrl.branch_taken_EX) begin
            do_flush = 1'b1;
        end else if (ctrl.load_use_hazard && state != LOAD_STALL) begin
            do_bubble  = 1'b1;
            state_next = LOAD_STALL;
        end else if (ctrl.imem_busy) begin
            do_imem = 1'b1;
        end
    end

    // A flush on a register always overrides a hold on the same register.
    assign if_id_flush_raw   = do_flush | do_imem;
    assign id_ex_flush_raw   = do_flush | do_bubble;
    assign ctrl.pc_stall     = RESET & (halt_now | freeze | do_bubble | do_imem);
    assign ctrl.if_id_stall  = RESET & (halt_now | freeze | do_bubble) & ~if_id_flush_raw;
    assign ctrl.if_id_flush  = RESET & if_id_flush_raw;
    assign ctrl.id_ex_stall  = RESET & (halt_now | freeze) & ~id_ex_flush_raw;
    assign ctrl.id_ex_flush  = RESET & id_ex_flush_raw;
    assign ctrl.ex_mem_stall = RESET & (halt_now | freeze);
    assign ctrl.mem_wb_stall = RESET & (halt_now | freeze);
    assign ctrl.halted       = halt_now;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= freeze ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_load;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_fl;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_load <= '0;
            cnt_mem  <= '0;
            cnt_fl   <= '0;
        end else begin
            if (do_bubble && cnt_load != '1) cnt_load <= cnt_load + CNT_W'(1);
            if (freeze && cnt_mem != '1)     cnt_mem  <= cnt_mem + CNT_W'(1);
            if (do_flush && cnt_fl != '1)    cnt_fl   <= cnt_fl + CNT_W'(1);
        end
    end

    assign ctrl.cnt_load_stall = cnt_load;
    assign ctrl.cnt_mem_wait   = cnt_mem;
    assign ctrl.cnt_flush      = cnt_fl;
`else
    assign ctrl.cnt_load_stall = '0;
    assign ctrl.cnt_mem_wait   = '0;
    assign ctrl.cnt_flush      = '0;
`endif
endmodule
